// File: rtl/dec_onehot2bin.sv
// ============================================================================
// Module   : dec_onehot2bin
// Purpose  : One-hot to binary decoder with malformed-word flag, registered
//            valid/ready output and one-entry skid buffer.
//            Optional saturating error counter enabled by ONEHOT_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_onehot2bin #(
    parameter int W     = 15,
    parameter int BW    = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ONEHOT_ERRCNT_EN
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt,
`endif
    input  logic             in_valid,
    input  logic [W-1:0]     in,
    output logic             in_ready,
    output logic             out_valid,
    output logic [BW-1:0]    out,
    output logic             out_err,
    input  logic             out_ready
);

    logic [BW-1:0] w_code;
    logic          w_err;
    logic          w_accept;
    logic          w_out_free;

    logic          r_out_valid;
    logic [BW-1:0] r_out;
    logic          r_out_err;
    logic          r_skid_valid;
    logic [BW-1:0] r_skid;
    logic          r_skid_err;

    // Lowest set bit wins; an all-zero word maps to code W.
    always_comb begin
        w_code = BW'(W);
        for (int k = W - 1; k >= 0; k--) begin
            if (in[k]) begin
                w_code = BW'(k);
            end
        end
    end

    assign w_err      = |(in & (in - W'(1)));
    assign w_accept   = in_valid & ~r_skid_valid;
    assign w_out_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_err   <= 1'b0;
        end else if (w_out_free) begin
            // The skid only ever holds data while in_ready is low, so it and a
            // fresh accept can never compete for the output register.
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out        <= r_skid;
                r_out_err    <= r_skid_err;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out       <= w_code;
                r_out_err   <= w_err;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid       <= w_code;
            r_skid_err   <= w_err;
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_err   = r_out_err;

`ifdef ONEHOT_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dec_onehot2bin.sv
// Directed table-driven bench for dec_onehot2bin plus hand-written sequences
// for back-pressure, counter saturation and asynchronous reset.
`default_nettype none

module tb_dec_onehot2bin;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [14:0] in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out;
    logic        out_err;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [1:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

`ifdef ONEHOT_ERRCNT_EN
    dec_onehot2bin #(.W(15), .BW(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .err_clr(err_clr), .err_cnt(err_cnt),
        .in_valid(in_valid), .in(in), .in_ready(in_ready),
        .out_valid(out_valid), .out(out), .out_err(out_err), .out_ready(out_ready)
    );
`else
    assign err_cnt = 2'd0;
    dec_onehot2bin #(.W(15), .BW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in(in), .in_ready(in_ready),
        .out_valid(out_valid), .out(out), .out_err(out_err), .out_ready(out_ready)
    );
`endif

    typedef struct {
        logic        in_valid;
        logic [14:0] in;
        logic        out_ready;
        logic        exp_valid;
        logic [3:0]  exp_out;
        logic        exp_err;
        logic        exp_in_ready;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic v, input logic [3:0] o,
                             input logic e, input logic r);
        check({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            check({name, ".out"}, {28'd0, out}, {28'd0, o});
            check({name, ".out_err"}, {31'd0, out_err}, {31'd0, e});
        end
        check({name, ".in_ready"}, {31'd0, in_ready}, {31'd0, r});
    endtask

    initial begin
        // Sweep of every legal code, back-to-back, each seen one cycle later.
        for (int k = 0; k < 15; k++) begin
            vecs[k] = '{1'b1, 15'(1) << k, 1'b1, 1'b1, 4'(k), 1'b0, 1'b1};
        end
        vecs[15] = '{1'b1, 15'h0000, 1'b1, 1'b1, 4'd15, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 15'h0012, 1'b1, 1'b1, 4'd1,  1'b1, 1'b1};
        vecs[17] = '{1'b1, 15'h4001, 1'b1, 1'b1, 4'd0,  1'b1, 1'b1};
        vecs[18] = '{1'b0, 15'h7FFF, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1};

        // Reset state
        rst = 1'b0;
        step();
        step();
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.out", {28'd0, out}, 32'd0);
        check("reset.out_err", {31'd0, out_err}, 32'd0);
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);
        check("reset.err_cnt", {30'd0, err_cnt}, 32'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 19; i++) begin
            in_valid  = vecs[i].in_valid;
            in        = vecs[i].in;
            out_ready = vecs[i].out_ready;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_out,
                      vecs[i].exp_err, vecs[i].exp_in_ready);
        end
`ifdef ONEHOT_ERRCNT_EN
        check("errcnt.after_table", {30'd0, err_cnt}, 32'd2);
`endif
        in = '0;

        // Back-pressure: 3 held in output, 5 in skid, 7 stalled upstream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in        = 15'(1) << 3;
        step();
        check_out("bp.first", 1'b1, 4'd3, 1'b0, 1'b1);
        in = 15'(1) << 5;
        step();
        check_out("bp.skid", 1'b1, 4'd3, 1'b0, 1'b0);
        in = 15'(1) << 7;
        step();
        check_out("bp.stall", 1'b1, 4'd3, 1'b0, 1'b0);
        step();
        check_out("bp.stall2", 1'b1, 4'd3, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        check_out("bp.drain5", 1'b1, 4'd5, 1'b0, 1'b1);
        step();
        check_out("bp.drain7", 1'b1, 4'd7, 1'b0, 1'b1);
        in_valid = 1'b0;
        in       = '0;
        step();
        check_out("bp.empty", 1'b0, 4'd0, 1'b0, 1'b1);

`ifdef ONEHOT_ERRCNT_EN
        // Saturation from 2 with five more malformed beats
        in_valid = 1'b1;
        in       = 15'h0006;
        for (int i = 0; i < 5; i++) step();
        check("errcnt.saturate", {30'd0, err_cnt}, 32'd3);
        check_out("errcnt.beat", 1'b1, 4'd1, 1'b1, 1'b1);
        err_clr = 1'b1;
        step();
        check("errcnt.clr_priority", {30'd0, err_cnt}, 32'd0);
        err_clr  = 1'b0;
        in_valid = 1'b0;
        in       = 15'h7FFF;
        step();
        step();
        check("errcnt.idle", {30'd0, err_cnt}, 32'd0);
        check_out("idle.no_beat", 1'b0, 4'd0, 1'b0, 1'b1);
`endif

        // Async reset with output register and skid both full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in        = 15'h0030;
        step();
        in = 15'h0041;
        step();
        check_out("prereset.full", 1'b1, 4'd4, 1'b1, 1'b0);
`ifdef ONEHOT_ERRCNT_EN
        check("prereset.err_cnt", {30'd0, err_cnt}, 32'd2);
`endif
        #2;
        rst = 1'b0;
        #1;
        check("areset.out_valid", {31'd0, out_valid}, 32'd0);
        check("areset.in_ready", {31'd0, in_ready}, 32'd1);
        check("areset.err_cnt", {30'd0, err_cnt}, 32'd0);
        in_valid = 1'b0;
        in       = '0;
        step();
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        check_out("postreset.empty", 1'b0, 4'd0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
